// File: rtl/pipe_stall_ctrl_if.sv
// ---------------------------------------------------------------------------------------------
// pipe_stall_ctrl_if
//
// Purpose: bundles the hazard-detect inputs and the stall/divider status outputs exchanged
// between the 5-stage pipeline datapath and the central stall scheduler.
//
// Signals:
//   id_rs_re, id_rs       ID instruction reads rs / rs address
//   id_rt_re, id_rt       ID instruction reads rt / rt address
//   ex_is_load            EX instruction is a load
//   ex_rf_we, ex_rf_waddr EX instruction writes the regfile / destination register
//   ex_div_start          EX holds a new div/divu
//   stallreq_if           IF requests a stall (instruction SRAM not ready)
//   stall[5:0]            per-stage hold: [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB [5]=WB
//   div_busy, div_done    divider occupied / one-cycle result-valid pulse
//   stallreq_id           load-use hazard present
//
// Modports: master = pipeline side, slave = stall scheduler.
// ---------------------------------------------------------------------------------------------
interface pipe_stall_ctrl_if;
    logic       id_rs_re;
    logic [4:0] id_rs;
    logic       id_rt_re;
    logic [4:0] id_rt;
    logic       ex_is_load;
    logic       ex_rf_we;
    logic [4:0] ex_rf_waddr;
    logic       ex_div_start;
    logic       stallreq_if;
    logic [5:0] stall;
    logic       div_busy;
    logic       div_done;
    logic       stallreq_id;

    modport master (
        output id_rs_re, id_rs, id_rt_re, id_rt,
        output ex_is_load, ex_rf_we, ex_rf_waddr, ex_div_start,
        output stallreq_if,
        input  stall, div_busy, div_done, stallreq_id
    );

    modport slave (
        input  id_rs_re, id_rs, id_rt_re, id_rt,
        input  ex_is_load, ex_rf_we, ex_rf_waddr, ex_div_start,
        input  stallreq_if,
        output stall, div_busy, div_done, stallreq_id
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------------------------
// pipe_stall_ctrl
//
// Purpose: central stall scheduler for the 5-stage MIPS pipeline. Merges load-use hazards,
// the multi-cycle divider and IF-side stall requests into the contiguous 6-bit stall bus,
// and owns the divider busy/done sequencing so EX needs no divider FSM.
//
// Parameters:
//   DIV_CYCLES  EX cycles a divide occupies, issue cycle included (2..63)
//   CNT_W       divider counter width, 2**CNT_W > DIV_CYCLES
//
// Ports:
//   clk     system clock
//   rst     synchronous, active-high reset
//   bus_io  pipe_stall_ctrl_if.slave: hazard inputs in, stall/divider status out
//
// Optional feature (macro STALL_PERF_CNT_EN): adds 32-bit wrapping counters
//   perf_lu_cnt_o   cycles where load-use is the winning stall source
//   perf_div_cnt_o  cycles with div_busy high
//   perf_if_cnt_o   cycles where the IF request is the winning stall source
// ---------------------------------------------------------------------------------------------
module pipe_stall_ctrl #(
    parameter int unsigned DIV_CYCLES = 33,
    parameter int unsigned CNT_W      = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_stall_ctrl_if.slave     bus_io
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0]          perf_lu_cnt_o,
    output logic [31:0]          perf_div_cnt_o,
    output logic [31:0]          perf_if_cnt_o
`endif
);

    // Elaboration-time parameter sanity.
    if (DIV_CYCLES < 2 || DIV_CYCLES > 63) begin : g_bad_div_cycles
        $error("pipe_stall_ctrl: DIV_CYCLES must be in 2..63");
    end
    if ((64'd1 << CNT_W) <= 64'(DIV_CYCLES)) begin : g_bad_cnt_w
        $error("pipe_stall_ctrl: CNT_W too narrow for DIV_CYCLES");
    end

    // Stall encodings; always contiguous from bit 0 so the bubble rule
    // (clear register k when stall[k] & ~stall[k+1]) yields exactly one bubble.
    localparam logic [5:0] StallDiv  = 6'b001111;  // bubble into MEM
    localparam logic [5:0] StallLu   = 6'b000111;  // bubble into EX
    localparam logic [5:0] StallIf   = 6'b000011;  // bubble into ID
    localparam logic [5:0] StallNone = 6'b000000;

    // Busy spans the issue cycle in idle plus DIV_CYCLES-1 run cycles.
    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(DIV_CYCLES - 2);

    typedef enum logic [1:0] {
        StIdle,
        StDivRun,
        StDivDone
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             lu;
    logic             div_busy;
    logic             div_done;
    logic [5:0]       stall;
    logic             win_lu;
    logic             win_if;

    // ------------------------------------------------------------------
    // Divider sequencing: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Divider sequencing: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                // Start is only honoured here; EX is frozen while busy so a
                // held start is the same instruction, not a new divide.
                if (bus_io.ex_div_start) begin
                    state_d = StDivRun;
                    cnt_d   = CntLoad;
                end
            end
            StDivRun: begin
                if (cnt_q == '0) begin
                    state_d = StDivDone;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDivDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Hazard detection and stall priority
    // ------------------------------------------------------------------
    always_comb begin
        lu       = 1'b0;
        div_busy = 1'b0;
        div_done = 1'b0;
        stall    = StallNone;
        win_lu   = 1'b0;
        win_if   = 1'b0;

        // Writes to $0 are discarded by the regfile, so they never create a hazard.
        lu = bus_io.ex_is_load && bus_io.ex_rf_we && (bus_io.ex_rf_waddr != 5'd0) &&
             ((bus_io.id_rs_re && (bus_io.id_rs == bus_io.ex_rf_waddr)) ||
              (bus_io.id_rt_re && (bus_io.id_rt == bus_io.ex_rf_waddr)));

        div_busy = (state_q == StDivRun) || ((state_q == StIdle) && bus_io.ex_div_start);
        div_done = (state_q == StDivDone);

        // Keep all status quiet while reset is held, so a start seen during
        // reset never shows up as a busy cycle.
        if (rst) begin
            lu       = 1'b0;
            div_busy = 1'b0;
            div_done = 1'b0;
        end

        if (div_busy) begin
            stall = StallDiv;
        end else if (lu) begin
            stall  = StallLu;
            win_lu = 1'b1;
        end else if (bus_io.stallreq_if) begin
            stall  = rst ? StallNone : StallIf;
            win_if = !rst;
        end
    end

    assign bus_io.stall       = stall;
    assign bus_io.div_busy    = div_busy;
    assign bus_io.div_done    = div_done;
    assign bus_io.stallreq_id = lu;

`ifdef STALL_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters (wrap modulo 2**32)
    // ------------------------------------------------------------------
    logic [31:0] perf_lu_cnt_q, perf_lu_cnt_d;
    logic [31:0] perf_div_cnt_q, perf_div_cnt_d;
    logic [31:0] perf_if_cnt_q, perf_if_cnt_d;

    always_comb begin
        perf_lu_cnt_d  = perf_lu_cnt_q;
        perf_div_cnt_d = perf_div_cnt_q;
        perf_if_cnt_d  = perf_if_cnt_q;
        if (win_lu) begin
            perf_lu_cnt_d = perf_lu_cnt_q + 32'd1;
        end
        if (div_busy) begin
            perf_div_cnt_d = perf_div_cnt_q + 32'd1;
        end
        if (win_if) begin
            perf_if_cnt_d = perf_if_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_cnt_q  <= '0;
            perf_div_cnt_q <= '0;
            perf_if_cnt_q  <= '0;
        end else begin
            perf_lu_cnt_q  <= perf_lu_cnt_d;
            perf_div_cnt_q <= perf_div_cnt_d;
            perf_if_cnt_q  <= perf_if_cnt_d;
        end
    end

    assign perf_lu_cnt_o  = perf_lu_cnt_q;
    assign perf_div_cnt_o = perf_div_cnt_q;
    assign perf_if_cnt_o  = perf_if_cnt_q;
`else
    // Winner flags only feed the optional counters.
    logic unused_win;
    assign unused_win = win_lu ^ win_if;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_pipe_stall_ctrl
//
// Scoreboard bench: each applied cycle pushes the expected {stall, div_busy, div_done,
// stallreq_id} computed by a remaining-cycles reference model; a negedge monitor pops and
// compares against the DUT. Directed cases first, then randomized traffic.
// ---------------------------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

    localparam int unsigned DIV_CYCLES = 33;
    localparam int unsigned CNT_W      = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if bus_if ();

`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_lu_cnt, perf_div_cnt, perf_if_cnt;
`endif

    pipe_stall_ctrl #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus_io         (bus_if.slave)
`ifdef STALL_PERF_CNT_EN
        ,
        .perf_lu_cnt_o  (perf_lu_cnt),
        .perf_div_cnt_o (perf_div_cnt),
        .perf_if_cnt_o  (perf_if_cnt)
`endif
    );

    // Scoreboard
    logic [8:0]  exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;

    // Reference model: busy cycles still owed and whether this cycle reports done.
    int          m_busy_left = 0;
    bit          m_done_now  = 1'b0;
    int unsigned m_lu_cnt    = 0;
    int unsigned m_div_cnt   = 0;
    int unsigned m_if_cnt    = 0;

    task automatic apply(input bit r, input bit rsre, input logic [4:0] rs, input bit rtre,
                         input logic [4:0] rt, input bit ld, input bit we, input logic [4:0] wa,
                         input bit ds, input bit sif);
        bit         hz;
        bit         busy;
        bit         done;
        logic [5:0] st;
        @(posedge clk);
        #1;
        rst                    = r;
        bus_if.id_rs_re        = rsre;
        bus_if.id_rs           = rs;
        bus_if.id_rt_re        = rtre;
        bus_if.id_rt           = rt;
        bus_if.ex_is_load      = ld;
        bus_if.ex_rf_we        = we;
        bus_if.ex_rf_waddr     = wa;
        bus_if.ex_div_start    = ds;
        bus_if.stallreq_if     = sif;

        hz   = ld && we && (wa != 0) && ((rsre && rs == wa) || (rtre && rt == wa));
        busy = 1'b0;
        done = 1'b0;
        if (r) begin
            m_busy_left = 0;
            m_done_now  = 1'b0;
            m_lu_cnt    = 0;
            m_div_cnt   = 0;
            m_if_cnt    = 0;
            exp_q.push_back(9'd0);
        end else begin
            if (m_done_now) begin
                done       = 1'b1;
                m_done_now = 1'b0;
            end else if (m_busy_left > 0) begin
                busy = 1'b1;
                m_busy_left--;
                if (m_busy_left == 0) m_done_now = 1'b1;
            end else if (ds) begin
                busy        = 1'b1;
                m_busy_left = DIV_CYCLES - 1;
            end
            if (busy)          st = 6'b001111;
            else if (hz)       st = 6'b000111;
            else if (sif)      st = 6'b000011;
            else               st = 6'b000000;
            if (busy)          m_div_cnt++;
            else if (hz)       m_lu_cnt++;
            else if (sif)      m_if_cnt++;
            exp_q.push_back({st, busy, done, hz});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
    endtask

    // Monitor: outputs are presented every cycle; sample mid-cycle.
    always @(negedge clk) begin
        logic [8:0] e;
        logic [8:0] a;
        cyc++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {bus_if.stall, bus_if.div_busy, bus_if.div_done, bus_if.stallreq_id};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL cycle%0d: got stall=%b busy=%b done=%b lu=%b, want stall=%b busy=%b done=%b lu=%b",
                         cyc, a[8:3], a[2], a[1], a[0], e[8:3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.id_rs_re     = 1'b0;
        bus_if.id_rs        = 5'd0;
        bus_if.id_rt_re     = 1'b0;
        bus_if.id_rt        = 5'd0;
        bus_if.ex_is_load   = 1'b0;
        bus_if.ex_rf_we     = 1'b0;
        bus_if.ex_rf_waddr  = 5'd0;
        bus_if.ex_div_start = 1'b0;
        bus_if.stallreq_if  = 1'b0;

        // Reset, then idle.
        apply(1, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
        apply(1, 1, 5'd8, 0, 5'd0, 1, 1, 5'd8, 1, 1);
        idle(2);

        // Load-use on rs, then same with $0 destination, then via rt.
        apply(0, 1, 5'd8, 0, 5'd0, 1, 1, 5'd8, 0, 0);
        apply(0, 1, 5'd0, 0, 5'd0, 1, 1, 5'd0, 0, 0);
        apply(0, 0, 5'd0, 1, 5'd9, 1, 1, 5'd9, 0, 0);
        apply(0, 1, 5'd9, 1, 5'd9, 1, 0, 5'd9, 0, 0);  // no regfile write
        apply(0, 1, 5'd9, 1, 5'd9, 0, 1, 5'd9, 0, 0);  // not a load
        idle(1);

        // IF stall alone, then with load-use.
        apply(0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1);
        apply(0, 1, 5'd5, 0, 5'd0, 1, 1, 5'd5, 0, 1);
        idle(1);

        // Plain divide: start held while busy (EX frozen), dropped at done.
        for (int i = 0; i < int'(DIV_CYCLES); i++) apply(0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 0);
        idle(3);

        // Divide coinciding with load-use: lu still present through done and one more cycle.
        for (int i = 0; i < int'(DIV_CYCLES); i++) apply(0, 1, 5'd7, 0, 5'd0, 1, 1, 5'd7, 1, 0);
        apply(0, 1, 5'd7, 0, 5'd0, 1, 1, 5'd7, 0, 0);
        apply(0, 1, 5'd7, 0, 5'd0, 1, 1, 5'd7, 0, 0);
        idle(2);

        // Reset in the middle of a divide: no done pulse afterwards.
        for (int i = 0; i < 11; i++) apply(0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 0);
        apply(1, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
        idle(DIV_CYCLES + 3);

        // Randomized traffic on a narrow register range so hazards are common.
        for (int i = 0; i < 900; i++) begin
            apply(($urandom_range(0, 149) == 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 3)),
                  ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) == 0));
        end
        idle(1);
        @(negedge clk);
        @(negedge clk);

`ifdef STALL_PERF_CNT_EN
        vectors++;
        if (perf_lu_cnt !== 32'(m_lu_cnt)) begin
            miscompares++;
            $display("FAIL perf_lu_cnt: got %0d, want %0d", perf_lu_cnt, m_lu_cnt);
        end
        vectors++;
        if (perf_div_cnt !== 32'(m_div_cnt)) begin
            miscompares++;
            $display("FAIL perf_div_cnt: got %0d, want %0d", perf_div_cnt, m_div_cnt);
        end
        vectors++;
        if (perf_if_cnt !== 32'(m_if_cnt)) begin
            miscompares++;
            $display("FAIL perf_if_cnt: got %0d, want %0d", perf_if_cnt, m_if_cnt);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
